gauss_frame_sched: RTL

- Frame-level sequencer for the 3x3 Gaussian filter engine (`gauss1`).
- Scans an IMG_W x IMG_H 8-bit image held in an external pixel RAM in raster order and fetches the 3x3 neighbourhood of each pixel, replicating (clamping) at the borders.
- For each pixel it presents the window to the engine, holds enable until the engine reports done, and writes the result to an output RAM.
- Sits between the frame buffers and the filter engine; a top-level controller issues one start per frame.

---
 rtl/gauss_frame_sched.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/gauss_frame_sched.sv
// Frame sequencer for the 3x3 Gaussian engine: walks the image in raster order,
// gathers each border-clamped neighbourhood, runs the engine and stores the result.
module gauss_frame_sched #(
   parameter int IMG_W   = 8,
   parameter int IMG_H   = 8,
   parameter int ADDR_W  = 12,
   parameter int TIMEOUT = 64
) (
   input  logic              clk_i_g,
   input  logic              rst_i_g,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic              rd_en_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic [7:0]        rd_data_i,
   output logic [7:0]        win_0_o,
   output logic [7:0]        win_1_o,
   output logic [7:0]        win_2_o,
   output logic [7:0]        win_3_o,
   output logic [7:0]        win_4_o,
   output logic [7:0]        win_5_o,
   output logic [7:0]        win_6_o,
   output logic [7:0]        win_7_o,
   output logic [7:0]        win_8_o,
   output logic              eng_en_o,
   input  logic [7:0]        eng_result_i,
   input  logic              eng_done_i,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [7:0]        wr_data_o
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] X_LAST  = ADDR_W'(IMG_W - 1);
   localparam logic [ADDR_W-1:0] Y_LAST  = ADDR_W'(IMG_H - 1);
   localparam logic [ADDR_W-1:0] ROW     = ADDR_W'(IMG_W);
   localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
   localparam logic [TW-1:0]     TO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_LOAD, S_RUN, S_WRITE, S_GAP, S_FIN
   } state_t;

   state_t            state_reg;
   logic [ADDR_W-1:0] x_reg, y_reg;
   logic [ADDR_W-1:0] x_next, y_next;
   logic [3:0]        k_reg;
   logic [TW-1:0]     tmo_reg;
   logic              abort_reg;
   logic              last_pix;

   // Neighbour coordinates use an explicit zero/last check so nothing wraps.
   function automatic logic [ADDR_W-1:0] win_addr(input logic [ADDR_W-1:0] x,
                                                  input logic [ADDR_W-1:0] y,
                                                  input logic [3:0]        k);
      logic [ADDR_W-1:0] xx, yy;
      if (k < 4'd3)      yy = (y == '0) ? y : y - ONE;
      else if (k < 4'd6) yy = y;
      else               yy = (y == Y_LAST) ? y : y + ONE;
      case (k)
         4'd0, 4'd3, 4'd6: xx = (x == '0) ? x : x - ONE;
         4'd1, 4'd4, 4'd7: xx = x;
         default:          xx = (x == X_LAST) ? x : x + ONE;
      endcase
      return yy * ROW + xx;
   endfunction

   always_comb begin
      x_next = x_reg + ONE;
      y_next = y_reg;
      if (x_reg == X_LAST) begin
         x_next = '0;
         y_next = y_reg + ONE;
      end
   end

   assign last_pix = (x_reg == X_LAST) && (y_reg == Y_LAST);

   always_ff @(posedge clk_i_g or negedge rst_i_g) begin
      if (!rst_i_g) begin
         state_reg <= S_IDLE;
         x_reg     <= '0;
         y_reg     <= '0;
         k_reg     <= '0;
         tmo_reg   <= '0;
         abort_reg <= 1'b0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         err_o     <= 1'b0;
         rd_en_o   <= 1'b0;
         rd_addr_o <= '0;
         eng_en_o  <= 1'b0;
         wr_en_o   <= 1'b0;
         wr_addr_o <= '0;
         wr_data_o <= '0;
      end else begin
         done_o <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (start_i) begin
                  err_o     <= 1'b0;
                  abort_reg <= 1'b0;
                  x_reg     <= '0;
                  y_reg     <= '0;
                  k_reg     <= '0;
                  busy_o    <= 1'b1;
                  rd_en_o   <= 1'b1;
                  rd_addr_o <= win_addr('0, '0, 4'd0);
                  state_reg <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (k_reg == 4'd8) begin
                  rd_en_o   <= 1'b0;
                  state_reg <= S_LOAD;
               end else begin
                  k_reg     <= k_reg + 4'd1;
                  rd_addr_o <= win_addr(x_reg, y_reg, k_reg + 4'd1);
               end
            end
            S_LOAD: begin
               tmo_reg   <= '0;
               eng_en_o  <= 1'b1;
               state_reg <= S_RUN;
            end
            S_RUN: begin
               if (eng_done_i) begin
                  wr_data_o <= eng_result_i;
                  wr_en_o   <= 1'b1;
                  wr_addr_o <= y_reg * ROW + x_reg;
                  state_reg <= S_WRITE;
               end else if (tmo_reg == TO_LAST) begin
                  err_o     <= 1'b1;
                  abort_reg <= 1'b1;
                  eng_en_o  <= 1'b0;
                  state_reg <= S_GAP;
               end else begin
                  tmo_reg <= tmo_reg + TW'(1);
               end
            end
            S_WRITE: begin
               // Enable stays up through WRITE so the engine finishes its clear cycle.
               wr_en_o   <= 1'b0;
               eng_en_o  <= 1'b0;
               state_reg <= S_GAP;
            end
            S_GAP: begin
               if (abort_reg || last_pix) begin
                  done_o    <= 1'b1;
                  state_reg <= S_FIN;
               end else begin
                  x_reg     <= x_next;
                  y_reg     <= y_next;
                  k_reg     <= '0;
                  rd_en_o   <= 1'b1;
                  rd_addr_o <= win_addr(x_next, y_next, 4'd0);
                  state_reg <= S_FETCH;
               end
            end
            S_FIN: begin
               busy_o    <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // Read data trails its strobe by one cycle, so slot gi fills while k = gi+1 (slot 8 in LOAD).
   for (genvar gi = 0; gi < 9; gi++) begin : g_win
      logic [7:0] win_reg;
      always_ff @(posedge clk_i_g or negedge rst_i_g) begin
         if (!rst_i_g)
            win_reg <= '0;
         else if ((state_reg == S_FETCH && k_reg == 4'(gi + 1)) ||
                  (state_reg == S_LOAD && gi == 8))
            win_reg <= rd_data_i;
      end
   end

   assign win_0_o = g_win[0].win_reg;
   assign win_1_o = g_win[1].win_reg;
   assign win_2_o = g_win[2].win_reg;
   assign win_3_o = g_win[3].win_reg;
   assign win_4_o = g_win[4].win_reg;
   assign win_5_o = g_win[5].win_reg;
   assign win_6_o = g_win[6].win_reg;
   assign win_7_o = g_win[7].win_reg;
   assign win_8_o = g_win[8].win_reg;

endmodule
